// File: rtl/uart_cfg_controller.sv
// uart_cfg_controller
//   Configuration sequencer between the UART command decoder and the VGA core.
//   Each decoded (address, data) command is answered with a one-cycle ack,
//   with err alongside it when the command is rejected. Baud changes wait for
//   the UART receiver to go idle. baud_ready then drops for SETTLE_CYCLES
//   cycles before the command is acknowledged.
//
// Ports:
//   clk, rst          : system clock, synchronous active-low reset
//   valid             : command valid level, held until acknowledged
//   address, data     : 4-bit command address and write data
//   uart_busy         : UART receiver is mid-frame
//   ack, err          : completion pulse and coincident reject flag
//   baud, baud_ready  : baud code and its stability flag to the clock handler
//   cfg_mode/fg/bg    : VGA configuration registers at addresses 1..3
module uart_cfg_controller #(
  parameter int       SETTLE_CYCLES = 16,
  parameter bit [2:0] DEFAULT_BAUD  = 3'b001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [3:0] address,
  input  logic [3:0] data,
  input  logic       uart_busy,
  output logic       ack,
  output logic       err,
  output logic [2:0] baud,
  output logic       baud_ready,
  output logic [3:0] cfg_mode,
  output logic [3:0] cfg_fg,
  output logic [3:0] cfg_bg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACK       = 2'd1,
    BAUD_WAIT = 2'd2,
    BAUD_HOLD = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic       armed_q, armed_d;
  logic       err_q, err_d;
  logic [2:0] pending_q, pending_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] baud_q, baud_d;
  logic       baud_ready_q, baud_ready_d;
  logic [3:0] cfg_mode_q, cfg_mode_d;
  logic [3:0] cfg_fg_q, cfg_fg_d;
  logic [3:0] cfg_bg_q, cfg_bg_d;

  logic       accept;
  logic [2:0] code;

  // State register: every flop of the block, reset synchronously.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      armed_q      <= 1'b1;
      err_q        <= 1'b0;
      pending_q    <= 3'd0;
      cnt_q        <= 8'd0;
      baud_q       <= DEFAULT_BAUD;
      baud_ready_q <= 1'b1;
      cfg_mode_q   <= 4'd0;
      cfg_fg_q     <= 4'd0;
      cfg_bg_q     <= 4'd0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      err_q        <= err_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      baud_q       <= baud_d;
      baud_ready_q <= baud_ready_d;
      cfg_mode_q   <= cfg_mode_d;
      cfg_fg_q     <= cfg_fg_d;
      cfg_bg_q     <= cfg_bg_d;
    end
  end

  // armed blocks a valid that is still high after its ack from being taken a
  // second time; it only re-arms once valid has been seen low.
  assign accept = (state_q == IDLE) && valid && armed_q;
  assign code   = data[2:0];

  // Next-state and register-update logic.
  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    err_d        = err_q;
    pending_d    = pending_q;
    cnt_d        = cnt_q;
    baud_d       = baud_q;
    baud_ready_d = baud_ready_q;
    cfg_mode_d   = cfg_mode_q;
    cfg_fg_d     = cfg_fg_q;
    cfg_bg_d     = cfg_bg_q;

    if (accept) begin
      armed_d = 1'b0;
    end else if (!valid) begin
      armed_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          err_d   = 1'b0;
          state_d = ACK;
          unique case (address)
            4'd0: begin
              if (code > 3'd4) begin
                err_d = 1'b1;
              end else if (code != baud_q) begin
                pending_d = code;
                state_d   = BAUD_WAIT;
              end
            end
            4'd1: cfg_mode_d = data;
            4'd2: cfg_fg_d   = data;
            4'd3: cfg_bg_d   = data;
            4'd4: begin
              if (data[0]) begin
                cfg_mode_d = 4'd0;
                cfg_fg_d   = 4'd0;
                cfg_bg_d   = 4'd0;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      BAUD_WAIT: begin
        if (!uart_busy) begin
          baud_d       = pending_q;
          baud_ready_d = 1'b0;
          cnt_d        = SETTLE_LOAD;
          state_d      = BAUD_HOLD;
        end
      end
      BAUD_HOLD: begin
        if (cnt_q == 8'd0) begin
          baud_ready_d = 1'b1;
          state_d      = ACK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: ack marks the ACK state, and err is qualified by it.
  always_comb begin
    ack        = (state_q == ACK);
    err        = (state_q == ACK) && err_q;
    baud       = baud_q;
    baud_ready = baud_ready_q;
    cfg_mode   = cfg_mode_q;
    cfg_fg     = cfg_fg_q;
    cfg_bg     = cfg_bg_q;
  end

endmodule

// File: tb/tb_uart_cfg_controller.sv
module tb_uart_cfg_controller;

  logic       clk;
  logic       rst;
  logic       valid;
  logic [3:0] address;
  logic [3:0] data;
  logic       uart_busy;
  logic       ack;
  logic       err;
  logic [2:0] baud;
  logic       baud_ready;
  logic [3:0] cfg_mode;
  logic [3:0] cfg_fg;
  logic [3:0] cfg_bg;

  int checks;
  int errors;

  // Monotonic event counters, read as differences by the stimulus tasks.
  int ack_total;
  int err_total;
  int err_with_ack_total;
  int ready_low_total;

  uart_cfg_controller #(
    .SETTLE_CYCLES(16),
    .DEFAULT_BAUD (3'b001)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .address   (address),
    .data      (data),
    .uart_busy (uart_busy),
    .ack       (ack),
    .err       (err),
    .baud      (baud),
    .baud_ready(baud_ready),
    .cfg_mode  (cfg_mode),
    .cfg_fg    (cfg_fg),
    .cfg_bg    (cfg_bg)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count output pulses mid-cycle, away from the rising edge.
  initial begin
    ack_total          = 0;
    err_total          = 0;
    err_with_ack_total = 0;
    ready_low_total    = 0;
  end
  always @(negedge clk) begin
    if (ack) ack_total++;
    if (err) err_total++;
    if (err && ack) err_with_ack_total++;
    if (!baud_ready) ready_low_total++;
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One-edge synchronous reset; leaves us at posedge+1.
  task automatic pulseReset();
    rst       = 1'b0;
    valid     = 1'b0;
    uart_busy = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Issue one command, hold valid until ack (bounded), then drop valid and idle.
  // Returns the number of acks, errs, coincident errs and baud_ready-low cycles.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] d, input int hold,
                               output int n_ack, output int n_err, output int n_ea,
                               output int n_low);
    int a0, e0, ea0, l0;
    bit seen;
    a0 = ack_total; e0 = err_total; ea0 = err_with_ack_total; l0 = ready_low_total;
    address = a;
    data    = d;
    valid   = 1'b1;
    seen    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ack) seen = 1'b1;
      if (seen && i >= hold - 1) break;
    end
    if (!seen) checkOutput("ack_timeout", 32'd0, 32'd1);
    valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    n_ack = ack_total - a0;
    n_err = err_total - e0;
    n_ea  = err_with_ack_total - ea0;
    n_low = ready_low_total - l0;
  endtask

  // Baud change with uart_busy high for 'busy' edges in BAUD_WAIT.
  // Index 0 is the accepting edge; baud loads at 1+busy, ack after 1+busy+16.
  task automatic runBaud(input logic [3:0] d, input int busy, input logic [2:0] old_baud);
    int fall_idx, rise_idx, ack_idx, n_ack, a0, l0;
    logic [2:0] baud_at_fall;
    bit early;
    a0 = ack_total; l0 = ready_low_total;
    fall_idx = -1; rise_idx = -1; ack_idx = -1; baud_at_fall = 3'd0; early = 1'b0;
    address   = 4'd0;
    data      = d;
    valid     = 1'b1;
    uart_busy = (busy > 0);
    for (int i = 0; i < 40 + busy; i++) begin
      @(posedge clk);
      #1;
      if (fall_idx < 0 && !baud_ready) begin
        fall_idx     = i;
        baud_at_fall = baud;
      end
      if (fall_idx < 0 && (baud !== old_baud || baud_ready !== 1'b1)) early = 1'b1;
      if (fall_idx >= 0 && rise_idx < 0 && baud_ready) rise_idx = i;
      if (ack && ack_idx < 0) begin
        ack_idx = i;
        valid   = 1'b0;
      end
      if (i == busy) uart_busy = 1'b0;
    end
    n_ack = ack_total - a0;
    checkOutput("baud_fall_idx", 32'(fall_idx), 32'(1 + busy));
    checkOutput("baud_new_value", 32'(baud_at_fall), 32'(d[2:0]));
    checkOutput("baud_stable_before", 32'(early), 32'd0);
    checkOutput("baud_rise_idx", 32'(rise_idx), 32'(17 + busy));
    checkOutput("baud_ack_idx", 32'(ack_idx), 32'(17 + busy));
    checkOutput("baud_ack_count", 32'(n_ack), 32'd1);
    checkOutput("baud_ready_low", 32'(ready_low_total - l0), 32'd16);
  endtask

  int n_ack, n_err, n_ea, n_low;

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    valid     = 1'b0;
    address   = 4'd0;
    data      = 4'd0;
    uart_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state.
    checkOutput("rst_baud", 32'(baud), 32'd1);
    checkOutput("rst_baud_ready", 32'(baud_ready), 32'd1);
    checkOutput("rst_cfg", {20'd0, cfg_mode, cfg_fg, cfg_bg}, 32'd0);
    checkOutput("rst_ack_err", {30'd0, ack, err}, 32'd0);

    // Plain write with valid held 5 cycles: single ack.
    applyStimulus(4'd2, 4'hA, 5, n_ack, n_err, n_ea, n_low);
    checkOutput("fg_value", 32'(cfg_fg), 32'hA);
    checkOutput("fg_ack_count", 32'(n_ack), 32'd1);
    checkOutput("fg_err_count", 32'(n_err), 32'd0);

    // Baud change with receiver idle.
    runBaud(4'h3, 0, 3'b001);
    checkOutput("baud_after_idle", 32'(baud), 32'd3);

    // Same change after reset, receiver busy for 10 cycles.
    pulseReset();
    checkOutput("rst2_baud", 32'(baud), 32'd1);
    runBaud(4'h3, 10, 3'b001);

    // Illegal baud code: err with ack, no change.
    pulseReset();
    applyStimulus(4'd0, 4'h6, 1, n_ack, n_err, n_ea, n_low);
    checkOutput("badbaud_ack", 32'(n_ack), 32'd1);
    checkOutput("badbaud_err_with_ack", 32'(n_ea), 32'd1);
    checkOutput("badbaud_baud", 32'(baud), 32'd1);
    checkOutput("badbaud_ready_low", 32'(n_low), 32'd0);

    // Illegal address: err with ack, registers untouched.
    applyStimulus(4'd9, 4'h1, 1, n_ack, n_err, n_ea, n_low);
    checkOutput("badaddr_ack", 32'(n_ack), 32'd1);
    checkOutput("badaddr_err_with_ack", 32'(n_ea), 32'd1);
    checkOutput("badaddr_cfg", {20'd0, cfg_mode, cfg_fg, cfg_bg}, 32'd0);

    // Same baud code as current: ack, no err, no baud_ready drop.
    applyStimulus(4'd0, 4'h1, 1, n_ack, n_err, n_ea, n_low);
    checkOutput("samebaud_ack", 32'(n_ack), 32'd1);
    checkOutput("samebaud_err", 32'(n_err), 32'd0);
    checkOutput("samebaud_ready_low", 32'(n_low), 32'd0);

    // Data[3] ignored on baud: 0xC -> code 4 is legal and changes baud.
    applyStimulus(4'd0, 4'hC, 1, n_ack, n_err, n_ea, n_low);
    checkOutput("baud_bit3_value", 32'(baud), 32'd4);
    checkOutput("baud_bit3_err", 32'(n_err), 32'd0);
    checkOutput("baud_bit3_low", 32'(n_low), 32'd16);

    // Register writes, a no-op control write, then a clear.
    applyStimulus(4'd1, 4'h5, 1, n_ack, n_err, n_ea, n_low);
    checkOutput("mode_ack", 32'(n_ack), 32'd1);
    applyStimulus(4'd2, 4'h6, 1, n_ack, n_err, n_ea, n_low);
    checkOutput("fg2_ack", 32'(n_ack), 32'd1);
    applyStimulus(4'd3, 4'h7, 1, n_ack, n_err, n_ea, n_low);
    checkOutput("bg_ack", 32'(n_ack), 32'd1);
    checkOutput("cfg_written", {20'd0, cfg_mode, cfg_fg, cfg_bg}, 32'h567);
    applyStimulus(4'd4, 4'hE, 1, n_ack, n_err, n_ea, n_low);
    checkOutput("noclear_cfg", {20'd0, cfg_mode, cfg_fg, cfg_bg}, 32'h567);
    checkOutput("noclear_err", 32'(n_err), 32'd0);
    applyStimulus(4'd4, 4'h1, 1, n_ack, n_err, n_ea, n_low);
    checkOutput("clear_cfg", {20'd0, cfg_mode, cfg_fg, cfg_bg}, 32'h000);
    checkOutput("clear_ack", 32'(n_ack), 32'd1);

    // Reset in the middle of BAUD_HOLD of a change to 4.
    pulseReset();
    begin
      int a0;
      a0 = ack_total;
      address = 4'd0;
      data    = 4'h4;
      valid   = 1'b1;
      repeat (6) begin
        @(posedge clk);
        #1;
      end
      checkOutput("hold_baud_mid", 32'(baud), 32'd4);
      checkOutput("hold_ready_mid", 32'(baud_ready), 32'd0);
      rst   = 1'b0;
      valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      checkOutput("abort_baud", 32'(baud), 32'd1);
      checkOutput("abort_ready", 32'(baud_ready), 32'd1);
      repeat (20) begin
        @(posedge clk);
        #1;
      end
      checkOutput("abort_no_ack", 32'(ack_total - a0), 32'd0);
    end
    applyStimulus(4'd1, 4'h9, 1, n_ack, n_err, n_ea, n_low);
    checkOutput("post_abort_mode", 32'(cfg_mode), 32'h9);
    checkOutput("post_abort_ack", 32'(n_ack), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
